// File: rtl/lcd_init_sequencer.sv
// Panel bring-up: RESX pulse, init command ROM with ms delays, then one frame of 9-bit pixel words over valid/ready.
// WORD/WORD_VALID are registered and held under backpressure; define COLOR_BARS_EN for 8 vertical bars instead of FILL_RGB.
module lcd_init_sequencer #(
   parameter int unsigned MS_CYCLES     = 16000,
   parameter int unsigned RESET_LOW_MS  = 1,
   parameter int unsigned RESET_WAIT_MS = 120,
   parameter int unsigned WIDTH         = 240,
   parameter int unsigned HEIGHT        = 320,
   parameter logic [17:0] FILL_RGB      = 18'h20E31
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       RESTART,
   output logic       RESX,
   output logic [8:0] WORD,
   output logic       WORD_VALID,
   input  logic       WORD_READY,
   output logic       BUSY,
   output logic       FRAME_DONE
);
   typedef enum logic [2:0] {RST_LOW, RST_WAIT, INIT, FILL, DONE} state_t;

   localparam logic [1:0]  T_CMD    = 2'd0;
   localparam logic [1:0]  T_DAT    = 2'd1;
   localparam logic [1:0]  T_DLY    = 2'd2;
   localparam logic [4:0]  ROM_LEN  = 5'd21;
   localparam logic [26:0] MS_LAST  = 27'(MS_CYCLES - 1);
   localparam logic [19:0] LAST_PIX = 20'(WIDTH * HEIGHT - 1);
   localparam logic [15:0] W_LAST   = 16'(WIDTH - 1);
   localparam logic [15:0] H_LAST   = 16'(HEIGHT - 1);

   function automatic logic [9:0] rom(input logic [4:0] i);
      case (i)
         5'd0:    rom = {T_CMD, 8'h01};
         5'd1:    rom = {T_DLY, 8'd150};
         5'd2:    rom = {T_CMD, 8'h11};
         5'd3:    rom = {T_DLY, 8'd120};
         5'd4:    rom = {T_CMD, 8'h3A};
         5'd5:    rom = {T_DAT, 8'h66};
         5'd6:    rom = {T_CMD, 8'h36};
         5'd7:    rom = {T_DAT, 8'h00};
         5'd8:    rom = {T_CMD, 8'h2A};
         5'd9:    rom = {T_DAT, 8'h00};
         5'd10:   rom = {T_DAT, 8'h00};
         5'd11:   rom = {T_DAT, W_LAST[15:8]};
         5'd12:   rom = {T_DAT, W_LAST[7:0]};
         5'd13:   rom = {T_CMD, 8'h2B};
         5'd14:   rom = {T_DAT, 8'h00};
         5'd15:   rom = {T_DAT, 8'h00};
         5'd16:   rom = {T_DAT, H_LAST[15:8]};
         5'd17:   rom = {T_DAT, H_LAST[7:0]};
         5'd18:   rom = {T_CMD, 8'h29};
         5'd19:   rom = {T_DLY, 8'd10};
         default: rom = {T_CMD, 8'h2C};
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [8:0]  wd_q, wd_d;
   logic        vld_q, vld_d;
   logic [4:0]  idx_q, idx_d;
   logic [26:0] cyc_q, cyc_d, cyc_nx;
   logic [7:0]  ms_q, ms_d, ms_nx;
   logic [7:0]  dly_q, dly_d;
   logic        dlying_q, dlying_d;
   logic [19:0] pix_q, pix_d;
   logic [1:0]  sub_q, sub_d;

   logic [7:0]  tgt;
   logic        expired, slot_free, xfer, fetch;
   logic [9:0]  ent;
   logic [1:0]  ld_sub;
   logic [17:0] ld_rgb;
   logic [5:0]  ld_comp;
   logic [8:0]  pix_word;

   // Cycle counter wraps every millisecond; ms_q counts whole ms against the current target.
   assign cyc_nx    = (cyc_q == MS_LAST) ? '0 : cyc_q + 27'd1;
   assign ms_nx     = (cyc_q == MS_LAST) ? ms_q + 8'd1 : ms_q;
   assign tgt       = (state_q == RST_LOW)  ? 8'(RESET_LOW_MS)  :
                      (state_q == RST_WAIT) ? 8'(RESET_WAIT_MS) : dly_q;
   assign expired   = (cyc_q == MS_LAST) && (ms_q == tgt - 8'd1);
   assign xfer      = vld_q & WORD_READY;
   assign slot_free = ~vld_q | WORD_READY;
   assign ent       = rom(idx_q);

   // Component of the pixel word about to be loaded (first load comes from INIT).
   assign ld_sub   = (state_q == FILL && sub_q != 2'd2) ? sub_q + 2'd1 : 2'd0;
   assign ld_comp  = (ld_sub == 2'd0) ? ld_rgb[17:12] :
                     (ld_sub == 2'd1) ? ld_rgb[11:6]  : ld_rgb[5:0];
   assign pix_word = {1'b1, ld_comp, 2'b00};

`ifdef COLOR_BARS_EN
   logic [9:0]  col_q, ld_col;
   logic [12:0] bar_div;
   logic [2:0]  bar;

   assign ld_col  = (state_q != FILL)             ? 10'd0 :
                    (sub_q != 2'd2)               ? col_q :
                    (col_q == 10'(WIDTH - 1))     ? 10'd0 : col_q + 10'd1;
   assign bar_div = {ld_col, 3'b000} / 13'(WIDTH);
   assign bar     = bar_div[2:0];
   assign ld_rgb  = {{6{bar[2]}}, {6{bar[1]}}, {6{bar[0]}}};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         col_q <= '0;
      else if (RESTART || state_q != FILL)
         col_q <= '0;
      else if (xfer)
         col_q <= ld_col;
   end
`else
   assign ld_rgb = FILL_RGB;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= RST_LOW;
         wd_q     <= '0;
         vld_q    <= 1'b0;
         idx_q    <= '0;
         cyc_q    <= '0;
         ms_q     <= '0;
         dly_q    <= '0;
         dlying_q <= 1'b0;
         pix_q    <= '0;
         sub_q    <= '0;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         vld_q    <= vld_d;
         idx_q    <= idx_d;
         cyc_q    <= cyc_d;
         ms_q     <= ms_d;
         dly_q    <= dly_d;
         dlying_q <= dlying_d;
         pix_q    <= pix_d;
         sub_q    <= sub_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wd_d     = wd_q;
      vld_d    = vld_q;
      idx_d    = idx_q;
      cyc_d    = cyc_q;
      ms_d     = ms_q;
      dly_d    = dly_q;
      dlying_d = dlying_q;
      pix_d    = pix_q;
      sub_d    = sub_q;
      fetch    = 1'b0;

      case (state_q)
         RST_LOW, RST_WAIT: begin
            if (expired) begin
               state_d = (state_q == RST_LOW) ? RST_WAIT : INIT;
               cyc_d   = '0;
               ms_d    = '0;
            end else begin
               cyc_d = cyc_nx;
               ms_d  = ms_nx;
            end
         end
         INIT: begin
            if (dlying_q) begin
               if (expired) begin
                  dlying_d = 1'b0;
                  fetch    = 1'b1;
               end else begin
                  cyc_d = cyc_nx;
                  ms_d  = ms_nx;
               end
            end else begin
               fetch = slot_free;
            end
            if (fetch) begin
               if (idx_q == ROM_LEN) begin
                  state_d = FILL;
                  wd_d    = pix_word;
                  vld_d   = 1'b1;
                  pix_d   = '0;
                  sub_d   = '0;
               end else begin
                  idx_d = idx_q + 5'd1;
                  if (ent[9:8] == T_DLY) begin
                     vld_d    = 1'b0;
                     dlying_d = 1'b1;
                     dly_d    = ent[7:0];
                     cyc_d    = '0;
                     ms_d     = '0;
                  end else begin
                     wd_d  = {(ent[9:8] == T_DAT), ent[7:0]};
                     vld_d = 1'b1;
                  end
               end
            end
         end
         FILL: begin
            if (xfer) begin
               if (sub_q == 2'd2 && pix_q == LAST_PIX) begin
                  state_d = DONE;
                  vld_d   = 1'b0;
               end else begin
                  wd_d  = pix_word;
                  sub_d = ld_sub;
                  if (sub_q == 2'd2)
                     pix_d = pix_q + 20'd1;
               end
            end
         end
         default: vld_d = 1'b0;
      endcase

      // Restart wins over any transfer in the same cycle; the pending word is dropped.
      if (RESTART) begin
         state_d  = RST_LOW;
         wd_d     = '0;
         vld_d    = 1'b0;
         idx_d    = '0;
         cyc_d    = '0;
         ms_d     = '0;
         dly_d    = '0;
         dlying_d = 1'b0;
         pix_d    = '0;
         sub_d    = '0;
      end
   end

   assign RESX       = (state_q != RST_LOW);
   assign BUSY       = (state_q != DONE);
   assign WORD       = wd_q;
   assign WORD_VALID = vld_q;
   assign FRAME_DONE = (state_q == FILL) && xfer && (sub_q == 2'd2) &&
                       (pix_q == LAST_PIX) && !RESTART;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: word list and timing model built from the command table, compared every cycle.
module tb_lcd_init_sequencer;
   localparam int MS       = 4;
   localparam int LOW_MS   = 1;
   localparam int WAIT_MS  = 2;
   localparam int W        = 4;
   localparam int H        = 2;
   localparam int RGB      = 'h20E31;
   localparam int LOW_CYC  = LOW_MS * MS;
   localparam int FIRST_K  = LOW_MS * MS + WAIT_MS * MS + 1;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       RESTART;
   logic       RESX;
   logic [8:0] WORD;
   logic       WORD_VALID;
   logic       WORD_READY;
   logic       BUSY;
   logic       FRAME_DONE;

   lcd_init_sequencer #(
      .MS_CYCLES(MS), .RESET_LOW_MS(LOW_MS), .RESET_WAIT_MS(WAIT_MS),
      .WIDTH(W), .HEIGHT(H), .FILL_RGB(18'h20E31)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .RESTART(RESTART), .RESX(RESX), .WORD(WORD),
      .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
   );

   initial forever #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;
   int k = 0, acc = 0, idle = 0, fd_cnt = 0, n_words = 0;
   bit hold_prev = 0, first_seen = 0, chk_gap = 0, mon_en = 0;
   int prev_word = 0;
   int rdy_mode = 1;  // 0 low, 1 high, 2 random
   int exp_w[$];
   int exp_gap[$];
   int cap_w[64];
   int cap_gap[64];
   int rom_k[21] = '{0,2,0,2,0,1,0,1,0,1,1,1,1,0,1,1,1,1,0,2,0};  // 0 cmd, 1 data, 2 delay ms
   int rom_v[21];

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h (seq cycle %0d, word %0d)", name, act, req, k, acc);
      end
   endtask

   task automatic build_model();
      int gap = 0;
      rom_v = '{'h01, 150, 'h11, 120, 'h3A, 'h66, 'h36, 'h00, 'h2A, 0, 0, (W-1) >> 8, (W-1) & 255,
                'h2B, 0, 0, (H-1) >> 8, (H-1) & 255, 'h29, 10, 'h2C};
      for (int i = 0; i < 21; i++) begin
         if (rom_k[i] == 2) gap += rom_v[i] * MS;
         else begin
            exp_w.push_back((rom_k[i] == 1 ? 256 : 0) + rom_v[i]);
            exp_gap.push_back(gap);
            gap = 0;
         end
      end
      for (int p = 0; p < W * H; p++) begin
         int col;
         int rgb;
         col = p % W;
`ifdef COLOR_BARS_EN
         begin
            int bar;
            bar = col * 8 / W;
            rgb = ((bar & 4) != 0 ? 'h3F000 : 0) | ((bar & 2) != 0 ? 'hFC0 : 0) | ((bar & 1) != 0 ? 'h3F : 0);
         end
`else
         rgb = RGB + 0 * col;
`endif
         for (int c = 2; c >= 0; c--) begin
            exp_w.push_back(256 + ((rgb >> (6 * c)) & 63) * 4);
            exp_gap.push_back(0);
         end
      end
      n_words = exp_w.size();
   endtask

   initial begin
      WORD_READY = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (rdy_mode == 2) WORD_READY = 1'($urandom_range(0, 1));
         else WORD_READY = (rdy_mode == 1);
      end
   end

   always @(negedge CLK) begin
      if (!RST_N || RESTART) begin
         k = 0; acc = 0; idle = 0; fd_cnt = 0; hold_prev = 0; first_seen = 0;
      end else if (mon_en) begin
         check("resx", int'(RESX), int'(k >= LOW_CYC));
         check("busy", int'(BUSY), int'(acc < n_words));
         if (k < FIRST_K) check("valid_early", int'(WORD_VALID), 0);
         if (WORD_VALID && !first_seen) begin
            check("first_valid_cycle", k, FIRST_K);
            first_seen = 1;
         end
         if (hold_prev) begin
            check("hold_valid", int'(WORD_VALID), 1);
            check("hold_word", int'(WORD), prev_word);
         end
         if (acc >= n_words) check("valid_after_frame", int'(WORD_VALID), 0);
         if (WORD_VALID && WORD_READY && acc < n_words) begin
            check("word", int'(WORD), exp_w[acc]);
            if (chk_gap && acc > 0) check("gap", idle, exp_gap[acc]);
            cap_w[acc] = int'(WORD);
            cap_gap[acc] = idle;
            check("frame_done", int'(FRAME_DONE), int'(acc == n_words - 1));
            acc++;
            idle = 0;
         end else begin
            check("frame_done_idle", int'(FRAME_DONE), 0);
            if (!WORD_VALID) idle++;
         end
         if (FRAME_DONE) fd_cnt++;
         hold_prev = WORD_VALID && !WORD_READY;
         prev_word = int'(WORD);
         k++;
      end
   end

   task automatic wait_acc(input int target, input int budget);
      int n = 0;
      while (acc < target && n < budget) begin
         @(posedge CLK);
         n++;
      end
      check("words_reached", int'(acc >= target), 1);
   endtask

   task automatic wait_frame(input int budget);
      wait_acc(n_words, budget);
      repeat (3) @(posedge CLK);
      #1;
      check("frame_done_count", fd_cnt, 1);
      check("busy_after_frame", int'(BUSY), 0);
   endtask

   task automatic pulse_restart();
      RESTART = 1'b1;
      @(posedge CLK);
      #1;
      RESTART = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_resx", int'(RESX), 0);
      check("rst_word", int'(WORD), 0);
      check("rst_valid", int'(WORD_VALID), 0);
      check("rst_busy", int'(BUSY), 1);
      check("rst_frame_done", int'(FRAME_DONE), 0);
   endtask

   initial begin
      RST_N = 1'b0;
      RESTART = 1'b0;
      build_model();
      repeat (3) @(posedge CLK);
      #1;
      check_reset_values();

      // Ready held high: exact timing and word list.
      mon_en = 1; chk_gap = 1; rdy_mode = 1;
      RST_N = 1'b1;
      wait_frame(5000);
      check("pin_w0", cap_w[0], 'h001);
      check("pin_w1", cap_w[1], 'h011);
      check("pin_w10", cap_w[10], 'h103);
      check("pin_w15", cap_w[15], 'h101);
      check("pin_w17", cap_w[17], 'h02C);
      check("pin_gap1", cap_gap[1], 600);
      check("pin_gap2", cap_gap[2], 480);
      check("pin_gap17", cap_gap[17], 40);
`ifndef COLOR_BARS_EN
      check("pin_w18", cap_w[18], 'h180);
      check("pin_w19", cap_w[19], 'h1E0);
      check("pin_w20", cap_w[20], 'h1C4);
      check("pin_w41", cap_w[41], 'h1C4);
`endif

      // Random backpressure.
      chk_gap = 0; rdy_mode = 2;
      pulse_restart();
      wait_frame(8000);

      // Restart while a fill word is held.
      pulse_restart();
      wait_acc(20, 8000);
      rdy_mode = 0;
      repeat (2) @(posedge CLK);
      #2;
      for (int n = 0; n < 20 && !WORD_VALID; n++) begin
         @(posedge CLK);
         #2;
      end
      check("held_before_restart", int'(WORD_VALID && !WORD_READY), 1);
      RESTART = 1'b1;
      chk_gap = 1;
      rdy_mode = 1;
      @(posedge CLK);
      #1;
      RESTART = 1'b0;
      @(negedge CLK);
      check("restart_valid", int'(WORD_VALID), 0);
      check("restart_resx", int'(RESX), 0);
      check("restart_busy", int'(BUSY), 1);
      wait_frame(5000);

      // Asynchronous reset in the middle of the init list.
      pulse_restart();
      wait_acc(5, 3000);
      #2;
      RST_N = 1'b0;
      #1;
      check_reset_values();
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      wait_frame(5000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, accepted %0d of %0d words", acc, n_words);
      $fatal(1, "watchdog");
   end
endmodule
